regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the datapath. It has two combinational read ports and two write ports: port 0 carries ALU results, port 1 carries load results. Optional features are write-to-read bypass, a hardwired zero register, a pending-load scoreboard, and a sequential clear sweep that zeroes the array one entry per cycle. It sits between decode (read addresses), the ALU/memory writeback paths, and hazard control, which consumes the scoreboard and the busy signal.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1, entry 0 reads 0 and ignores writes and scoreboard sets
- BYPASS, 1, when 1, a read of an address written in the same cycle returns the incoming data

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- A1, A2  in  ADDR_W  read addresses
- RD1, RD2  out  DATA_W  read data, combinational
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write port 0 (ALU)
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write port 1 (load)
- sb_set, sb_addr  in  1/ADDR_W  mark entry as pending load
- pend1, pend2  out  1  pending bit for A1, A2
- clear_req  in  1  request clear sweep
- busy  out  1  sweep in progress

## Operation
- Reset (async):
  - all entries = 0; all pending bits = 0; FSM = IDLE; sweep counter = 0.
  - Outputs RD1/RD2 = 0, pend1/pend2 = 0, busy = 0.
- Writes: at the rising edge, entry[wa0] <= wd0 if we0; entry[wa1] <= wd1 if we1.
  - Same address on both ports in the same cycle: port 1 wins.
  - ZERO_REG=1: any write to address 0 is discarded.
- Reads: RD = entry[A].
  - ZERO_REG=1 and A = 0: RD = 0 regardless of writes.
  - BYPASS=1 and A matches an active write this cycle: RD = that wd, with port 1 having priority. Otherwise RD = the stored value.
- Scoreboard: one pending bit per entry.
  - sb_set sets bit[sb_addr] at the edge.
  - we1 clears bit[wa1] at the edge.
  - Set and clear of the same address in the same cycle: set wins.
  - we0 does not affect pending bits.
  - pend = bit[A]. With BYPASS=1, a clear in the current cycle makes pend read 0. pend is 0 for address 0 when ZERO_REG=1.
- Clear FSM states:
  - IDLE: clear_req at an edge moves to SWEEP, with counter = 0 and all pending bits cleared.
  - SWEEP: each edge writes entry[counter] <= 0 and increments counter. At counter = DEPTH-1, that edge clears the last entry and returns to IDLE.
  - busy = 1 exactly while in SWEEP.
- During SWEEP: we0, we1, sb_set and clear_req are ignored. Reads remain live, returning a mix of cleared and old values; bypass is disabled.
- Reset mid-sweep: abort to IDLE immediately with all state cleared.

## Timing
- Read latency 0 (combinational).
- Write visible via stored path 1 edge after the write; via bypass in the same cycle.
- Scoreboard update latency is 1 edge.
- clear_req sampled at edge N gives busy = 1 from N through N+DEPTH, i.e. busy is high for exactly DEPTH cycles. Array is fully zero after edge N+DEPTH.
- Counter width is ADDR_W. It reaches DEPTH-1 and the FSM exits without wrap.
- No combinational path from clear_req to any output.

## Structure
- Shared package regfile_pkg:
  - FSM state enum {IDLE, SWEEP}
  - default DATA_W/ADDR_W constants
  - ZERO_ADDR constant
- One sub-module, regfile_scoreboard:
  - DEPTH pending bits with set/clear priority, flush input, two combinational lookup ports.
- The top level holds the array, the write arbitration, the bypass muxes and the sweep FSM.

## Test plan
- Reset then read all addresses: RD1/RD2 = 0, pend = 0, busy = 0. Assert rst mid-sweep: busy drops immediately and all entries read 0.
- Write 0x5A to addr 3 via port 0 with A1 = 3 in the same cycle: BYPASS=1 gives RD1 = 0x5A that cycle; BYPASS=0 gives the old value, then 0x5A next cycle.
- Same-cycle collision: port 0 writes 0x11 and port 1 writes 0x22 to addr 7. Next cycle RD = 0x22.
- ZERO_REG=1: write 0xFF to addr 0 and sb_set addr 0. RD of 0 stays 0 and pend stays 0.
- Scoreboard:
  - sb_set addr 4 gives pend = 1 next cycle.
  - we1 to addr 4 clears it next cycle.
  - sb_set and we1 on addr 4 together leave pend = 1.
- Sweep:
  - Fill all entries with nonzero data, then pulse clear_req. busy stays high for DEPTH cycles and writes attempted during it are dropped.
  - After busy falls, every entry reads 0 and every pending bit is 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - Default width constants used as parameter defaults by regfile_mp.
//   - ZERO_ADDR: index of the hardwired zero register.
//   - sweep_state_t: states of the clear-sweep FSM.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register entry.
// Ports:
//   clk, rst          clock, async active-high reset
//   set, set_addr     mark entry as pending at the edge
//   clr, clr_addr     clear entry at the edge (set wins on the same address)
//   flush             clear every bit at the edge (overrides set/clr)
//   addr1, addr2      lookup addresses
//   bit1, bit2        raw stored pending bits, combinational
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic              bit1,
    output logic              bit2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            // Clear first so a same-address set overrides it.
            if (clr) pend[clr_addr] <= 1'b0;
            if (set) pend[set_addr] <= 1'b1;
        end
    end

    assign bit1 = pend[addr1];
    assign bit2 = pend[addr2];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write ports
// (port 0 = ALU, port 1 = load, port 1 wins on collision), optional
// write-to-read bypass, optional hardwired zero register, pending-load
// scoreboard and a one-entry-per-cycle clear sweep.
// Ports:
//   clk, rst                 clock, async active-high reset
//   A1, A2 / RD1, RD2        read addresses / combinational read data
//   we0, wa0, wd0            write port 0 (ALU)
//   we1, wa1, wd1            write port 1 (load), also clears pending bit
//   sb_set, sb_addr          mark entry as pending load
//   pend1, pend2             pending bit for A1 / A2
//   clear_req, busy          start clear sweep / sweep in progress
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              pend1,
    output logic              pend2,
    input  logic              clear_req,
    output logic              busy
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    sweep_state_t                 state, state_nxt;
    logic [ADDR_W-1:0]            cnt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == ADDR_W'(ZERO_ADDR));
    endfunction

    // Qualified requests: everything from the write/scoreboard side is
    // ignored while the sweep owns the array.
    logic wr0, wr1, set_ok, clr_ok, flush;
    assign wr0    = we0 && !busy && !is_zero(wa0);
    assign wr1    = we1 && !busy && !is_zero(wa1);
    assign set_ok = sb_set && !busy && !is_zero(sb_addr);
    assign clr_ok = we1 && !busy;
    assign flush  = (state == IDLE) && clear_req;

    // Sweep FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req)   state_nxt = SWEEP;
            SWEEP:   if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SWEEP);
    end

    // Array and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
            cnt <= '0;
        end else if (busy) begin
            mem[cnt] <= '0;
            cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else begin
            cnt <= '0;
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;  // later assignment: port 1 wins
        end
    end

    logic [1:0] pend_raw;

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set      (set_ok),
        .set_addr (sb_addr),
        .clr      (clr_ok),
        .clr_addr (wa1),
        .flush    (flush),
        .addr1    (A1),
        .addr2    (A2),
        .bit1     (pend_raw[0]),
        .bit2     (pend_raw[1])
    );

    // Read muxes: stored value, then bypass (port 1 last so it has
    // priority), then the zero-register override.
    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][DATA_W-1:0] rd;
    logic [1:0]             pd;

    assign ra = {A2, A1};

    always_comb begin
        rd = '0;
        pd = '0;
        for (int g = 0; g < 2; g++) begin
            rd[g] = mem[ra[g]];
            pd[g] = pend_raw[g];
            if (BYPASS) begin
                if (wr0 && wa0 == ra[g])    rd[g] = wd0;
                if (wr1 && wa1 == ra[g])    rd[g] = wd1;
                if (clr_ok && wa1 == ra[g]) pd[g] = 1'b0;
            end
            if (is_zero(ra[g])) begin
                rd[g] = '0;
                pd[g] = 1'b0;
            end
        end
    end

    assign RD1   = rd[0];
    assign RD2   = rd[1];
    assign pend1 = pd[0];
    assign pend2 = pd[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
// u_dut uses BYPASS=1/ZERO_REG=1, u_nb uses BYPASS=0/ZERO_REG=0 on the
// same inputs.
module tb_regfile_mp;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] A1, A2, wa0, wa1, sb_addr;
    logic [DW-1:0] wd0, wd1;
    logic          we0, we1, sb_set, clear_req;
    logic [DW-1:0] RD1, RD2, nb_rd1, nb_rd2;
    logic          pend1, pend2, busy, nb_pend1, nb_pend2, nb_busy;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(pend1), .pend2(pend2),
        .clear_req(clear_req), .busy(busy)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(nb_rd1), .RD2(nb_rd2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend1(nb_pend1), .pend2(nb_pend2),
        .clear_req(clear_req), .busy(nb_busy)
    );

    // kind: 0 RD1, 1 RD2, 2 pend1, 3 pend2, 4 busy,
    //       5 nb RD1, 6 nb busy, 7 nb pend1, 8 nb RD2, 9 nb pend2
    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] exp;
        logic [7:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                4'd0:    act = RD1;
                4'd1:    act = RD2;
                4'd2:    act = {7'd0, pend1};
                4'd3:    act = {7'd0, pend2};
                4'd4:    act = {7'd0, busy};
                4'd5:    act = nb_rd1;
                4'd6:    act = {7'd0, nb_busy};
                4'd7:    act = {7'd0, nb_pend1};
                4'd8:    act = nb_rd2;
                default: act = {7'd0, nb_pend2};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL kind%0d tag%0d got %h want %h (t=%0t)",
                         e.kind, e.tag, act, e.exp, $time);
            end
        end
    end

    task automatic chk(input logic [3:0] k, input logic [7:0] v, input logic [7:0] t);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.tag  = t;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        A1 = '0; A2 = '0; wa0 = '0; wa1 = '0; sb_addr = '0;
        wd0 = '0; wd1 = '0;
        idle_in();

        // Reset state across all addresses
        for (int a = 0; a < DEPTH; a++) begin
            cyc();
            A1 = AW'(a);
            A2 = AW'(DEPTH - 1 - a);
            chk(0, 8'h00, 1); chk(1, 8'h00, 1);
            chk(2, 8'h00, 1); chk(3, 8'h00, 1); chk(4, 8'h00, 1);
        end
        cyc();
        rst = 1'b0;

        // Bypass vs. stored path
        cyc();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 8'h5A; A1 = 5'd3;
        chk(0, 8'h5A, 2); chk(5, 8'h00, 2);
        cyc();
        idle_in();
        chk(0, 8'h5A, 3); chk(5, 8'h5A, 3);

        // Same-address collision: port 1 wins
        cyc();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 8'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 8'h22; A2 = 5'd7;
        chk(1, 8'h22, 4);
        cyc();
        idle_in(); A1 = 5'd7;
        chk(1, 8'h22, 5); chk(5, 8'h22, 5);

        // Zero register
        cyc();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 8'hFF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 8'hFF;
        sb_set = 1'b1; sb_addr = 5'd0; A1 = 5'd0;
        chk(0, 8'h00, 6); chk(2, 8'h00, 6); chk(5, 8'h00, 6);
        cyc();
        idle_in();
        chk(0, 8'h00, 7); chk(2, 8'h00, 7); chk(5, 8'hFF, 7); chk(7, 8'h01, 7);

        // Scoreboard set / clear / set-wins
        cyc();
        sb_set = 1'b1; sb_addr = 5'd4; A1 = 5'd4; A2 = 5'd5;
        chk(2, 8'h00, 8);
        cyc();
        idle_in();
        chk(2, 8'h01, 9); chk(3, 8'h00, 9);
        cyc();
        we1 = 1'b1; wa1 = 5'd4; wd1 = 8'h44;
        chk(2, 8'h00, 10); chk(0, 8'h44, 10);
        cyc();
        idle_in();
        chk(2, 8'h00, 11); chk(0, 8'h44, 11);
        cyc();
        sb_set = 1'b1; sb_addr = 5'd4;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 8'h45;
        chk(2, 8'h00, 12);
        cyc();
        idle_in();
        chk(2, 8'h01, 13); chk(0, 8'h45, 13);

        // Fill every entry, mark entry 9 pending on the last write
        for (int a = 1; a < DEPTH; a++) begin
            cyc();
            we0 = 1'b1; wa0 = AW'(a); wd0 = 8'(a) | 8'h80;
            if (a == DEPTH - 1) begin
                sb_set = 1'b1; sb_addr = 5'd9;
            end
        end
        cyc();
        idle_in(); A1 = 5'd10; A2 = 5'd9;
        chk(0, 8'h8A, 14); chk(5, 8'h8A, 14); chk(3, 8'h01, 14);

        // Sweep: busy for DEPTH cycles, writes/sets dropped, no bypass
        cyc();
        clear_req = 1'b1;
        chk(4, 8'h00, 15);
        for (int k = 0; k < DEPTH; k++) begin
            cyc();
            clear_req = (k >= 1 && k <= DEPTH - 2);
            we0 = 1'b1; wa0 = 5'd10; wd0 = 8'h77;
            sb_set = 1'b1; sb_addr = 5'd12;
            chk(4, 8'h01, 16); chk(6, 8'h01, 16);
            chk(0, (k <= 10) ? 8'h8A : 8'h00, 17);
            chk(5, (k <= 10) ? 8'h8A : 8'h00, 17);
            if (k == 0) chk(3, 8'h00, 18);
        end
        cyc();
        idle_in();
        chk(4, 8'h00, 19); chk(6, 8'h00, 19);
        for (int a = 0; a < DEPTH; a++) begin
            cyc();
            A1 = AW'(a); A2 = AW'(a);
            chk(0, 8'h00, 20); chk(2, 8'h00, 20); chk(5, 8'h00, 20);
            chk(8, 8'h00, 20); chk(9, 8'h00, 20); chk(4, 8'h00, 20);
        end

        // Reset in the middle of a sweep
        cyc();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 8'h55; sb_set = 1'b1; sb_addr = 5'd6;
        cyc();
        idle_in(); A1 = 5'd5; A2 = 5'd6;
        chk(0, 8'h55, 21); chk(3, 8'h01, 21);
        cyc();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        chk(4, 8'h01, 22); chk(0, 8'h55, 22); chk(3, 8'h00, 22);
        cyc();
        cyc();
        rst = 1'b1;
        chk(4, 8'h00, 23); chk(6, 8'h00, 23); chk(0, 8'h00, 23); chk(5, 8'h00, 23);
        for (int a = 0; a < 8; a++) begin
            cyc();
            A1 = AW'(a);
            chk(0, 8'h00, 24); chk(5, 8'h00, 24); chk(4, 8'h00, 24);
        end
        cyc();
        rst = 1'b0;
        A1 = 5'd5;
        cyc();
        chk(4, 8'h00, 25); chk(0, 8'h00, 25);

        // Drain the scoreboard with a bounded wait
        repeat (4) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
